// File: rtl/ncl_alu_hs_if.sv
// Dual-rail operand/result bundle between producer, ALU shell and consumer.
interface ncl_alu_hs_if #(
  parameter int WIDTH = 5
);
  logic [2*WIDTH-1:0] a_dr;
  logic [2*WIDTH-1:0] b_dr;
  logic [5:0]         op_dr;
  logic [1:0]         cin_dr;
  logic               ki;
  logic               ko;
  logic [2*WIDTH-1:0] out_dr;
  logic [1:0]         ovf_dr;
  logic [1:0]         neg_dr;
  logic [1:0]         zero_dr;
  logic               err;

  // Environment side: drives operands and the consumer acknowledge.
  modport master (
    output a_dr, b_dr, op_dr, cin_dr, ki,
    input  ko, out_dr, ovf_dr, neg_dr, zero_dr, err
  );

  // ALU side.
  modport slave (
    input  a_dr, b_dr, op_dr, cin_dr, ki,
    output ko, out_dr, ovf_dr, neg_dr, zero_dr, err
  );
endinterface

// File: rtl/ncl_alu_hs.sv
// Dual-rail ALU with a clocked four-phase DATA/NULL handshake shell.
//
//  state     | meaning
//  ----------+------------------------------------------------------
//  WAIT_DATA | ko=1, outputs NULL, waiting for complete DATA and ki=1
//  HOLD_DATA | ko=0, result frozen as DATA until ki=0 and inputs NULL
//  HOLD_NULL | ko=0, outputs NULL, waiting for consumer ki=1
//  ERROR     | ko=0, outputs NULL, err=1; left only by reset
module ncl_alu_hs #(
  parameter int WIDTH = 5
) (
  input logic         clk,
  input logic         rst,
  ncl_alu_hs_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    HOLD_DATA = 2'd1,
    HOLD_NULL = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_ko;
  logic               r_err;
  logic [2*WIDTH-1:0] r_out_dr;
  logic [1:0]         r_ovf_dr;
  logic [1:0]         r_neg_dr;
  logic [1:0]         r_zero_dr;

  logic [WIDTH-1:0] w_a1, w_a0, w_b1, w_b0;
  logic [2:0]       w_op1, w_op0;
  logic             w_c1, w_c0;
  logic             w_illegal, w_in_data, w_in_null;
  logic [WIDTH-1:0] w_cin_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  // Split each bus into its rail-1 and rail-0 vectors.
  always_comb begin
    w_a1  = '0;
    w_a0  = '0;
    w_b1  = '0;
    w_b0  = '0;
    w_op1 = '0;
    w_op0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_a1[i] = bus.a_dr[2*i+1];
      w_a0[i] = bus.a_dr[2*i];
      w_b1[i] = bus.b_dr[2*i+1];
      w_b0[i] = bus.b_dr[2*i];
    end
    for (int j = 0; j < 3; j++) begin
      w_op1[j] = bus.op_dr[2*j+1];
      w_op0[j] = bus.op_dr[2*j];
    end
  end

  assign w_c1 = bus.cin_dr[1];
  assign w_c0 = bus.cin_dr[0];

  assign w_illegal = (|(w_a1 & w_a0)) | (|(w_b1 & w_b0)) |
                     (|(w_op1 & w_op0)) | (w_c1 & w_c0);
  assign w_in_data = (&(w_a1 ^ w_a0)) & (&(w_b1 ^ w_b0)) &
                     (&(w_op1 ^ w_op0)) & (w_c1 ^ w_c0);
  assign w_in_null = ~(|{w_a1, w_a0, w_b1, w_b0, w_op1, w_op0, w_c1, w_c0});

  assign w_cin_ext = {{(WIDTH-1){1'b0}}, w_c1};

  // Single-rail ALU on the rail-1 values; only meaningful when w_in_data.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_op1)
      3'b000: begin
        w_res = w_a1 + w_b1 + w_cin_ext;
        w_ovf = (w_a1[WIDTH-1] == w_b1[WIDTH-1]) && (w_res[WIDTH-1] != w_a1[WIDTH-1]);
      end
      3'b001: begin
        w_res = w_a1 - w_b1 - w_cin_ext;
        w_ovf = (w_a1[WIDTH-1] != w_b1[WIDTH-1]) && (w_res[WIDTH-1] != w_a1[WIDTH-1]);
      end
      3'b010:  w_res = w_a1 ^ w_b1;
      3'b011:  w_res = w_a1 & w_b1;
      3'b100:  w_res = w_a1 | w_b1;
      3'b101:  w_res = w_a1;
      default: w_res = '0;
    endcase
  end

  function automatic logic [2*WIDTH-1:0] enc_word(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  function automatic logic [1:0] enc_bit(input logic v);
    return {v, ~v};
  endfunction

  // Handshake FSM; every output pair is registered and updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= WAIT_DATA;
      r_ko      <= 1'b1;
      r_err     <= 1'b0;
      r_out_dr  <= '0;
      r_ovf_dr  <= 2'b00;
      r_neg_dr  <= 2'b00;
      r_zero_dr <= 2'b00;
    end else if (w_illegal) begin
      r_state   <= ERROR;
      r_ko      <= 1'b0;
      r_err     <= 1'b1;
      r_out_dr  <= '0;
      r_ovf_dr  <= 2'b00;
      r_neg_dr  <= 2'b00;
      r_zero_dr <= 2'b00;
    end else begin
      case (r_state)
        WAIT_DATA: begin
          if (w_in_data && bus.ki) begin
            r_state   <= HOLD_DATA;
            r_ko      <= 1'b0;
            r_out_dr  <= enc_word(w_res);
            r_ovf_dr  <= enc_bit(w_ovf);
            r_neg_dr  <= enc_bit(w_res[WIDTH-1]);
            r_zero_dr <= enc_bit(w_res == '0);
          end
        end
        HOLD_DATA: begin
          if (!bus.ki && w_in_null) begin
            r_state   <= HOLD_NULL;
            r_out_dr  <= '0;
            r_ovf_dr  <= 2'b00;
            r_neg_dr  <= 2'b00;
            r_zero_dr <= 2'b00;
          end
        end
        HOLD_NULL: begin
          if (bus.ki) begin
            r_state <= WAIT_DATA;
            r_ko    <= 1'b1;
          end
        end
        default: begin
          r_state <= ERROR;
          r_ko    <= 1'b0;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ko      = r_ko;
  assign bus.err     = r_err;
  assign bus.out_dr  = r_out_dr;
  assign bus.ovf_dr  = r_ovf_dr;
  assign bus.neg_dr  = r_neg_dr;
  assign bus.zero_dr = r_zero_dr;

endmodule

// File: tb/tb_ncl_alu_hs.sv
// Directed bench for the dual-rail ALU handshake shell.
module tb_ncl_alu_hs;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ncl_alu_hs_if #(.WIDTH(W)) bus ();
  ncl_alu_hs #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Observed vector: {ko, err, out_dr, ovf_dr, neg_dr, zero_dr}
  logic [17:0] obs;
  assign obs = {bus.ko, bus.err, bus.out_dr, bus.ovf_dr, bus.neg_dr, bus.zero_dr};

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [5:0] enc3(input logic [2:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] encf(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  // Expected DATA vector with ko=0, err=0.
  function automatic logic [17:0] exp_data(input logic [W-1:0] r, input logic o,
                                            input logic n, input logic z);
    return {1'b0, 1'b0, enc(r), encf(o), encf(n), encf(z)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_null();
    bus.a_dr   = '0;
    bus.b_dr   = '0;
    bus.op_dr  = '0;
    bus.cin_dr = '0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
    bus.a_dr   = enc(a);
    bus.b_dr   = enc(b);
    bus.op_dr  = enc3(op);
    bus.cin_dr = encf(cin);
  endtask

  task automatic return_null();
    drive_null();
    bus.ki = 1'b0;
    tick();
    bus.ki = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_null();
    bus.ki = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    drive(3'b000, 5'd7, 5'd5, 1'b0);
    tick();
    checks++;
    if (obs !== exp_data(5'b01100, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL pre_reset_data got=%h want=%h", obs, exp_data(5'b01100, 1'b0, 1'b0, 1'b0));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    drive_null();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    logic [2:0]   t_op  [9];
    logic [W-1:0] t_a   [9];
    logic [W-1:0] t_b   [9];
    logic         t_cin [9];
    logic [W-1:0] t_res [9];
    logic [2:0]   t_fl  [9];  // {ovf, neg, zero}
    t_op[0]=3'b000; t_a[0]=5'b00111; t_b[0]=5'b00101; t_cin[0]=0; t_res[0]=5'b01100; t_fl[0]=3'b000;
    t_op[1]=3'b001; t_a[1]=5'b10000; t_b[1]=5'b00001; t_cin[1]=0; t_res[1]=5'b01111; t_fl[1]=3'b100;
    t_op[2]=3'b000; t_a[2]=5'b01111; t_b[2]=5'b00001; t_cin[2]=0; t_res[2]=5'b10000; t_fl[2]=3'b110;
    t_op[3]=3'b001; t_a[3]=5'b00101; t_b[3]=5'b00011; t_cin[3]=1; t_res[3]=5'b00001; t_fl[3]=3'b000;
    t_op[4]=3'b011; t_a[4]=5'b01101; t_b[4]=5'b00110; t_cin[4]=0; t_res[4]=5'b00100; t_fl[4]=3'b000;
    t_op[5]=3'b100; t_a[5]=5'b01101; t_b[5]=5'b00110; t_cin[5]=0; t_res[5]=5'b01111; t_fl[5]=3'b000;
    t_op[6]=3'b101; t_a[6]=5'b01101; t_b[6]=5'b00110; t_cin[6]=1; t_res[6]=5'b01101; t_fl[6]=3'b000;
    t_op[7]=3'b010; t_a[7]=5'b10101; t_b[7]=5'b10101; t_cin[7]=0; t_res[7]=5'b00000; t_fl[7]=3'b001;
    t_op[8]=3'b110; t_a[8]=5'b00111; t_b[8]=5'b00101; t_cin[8]=0; t_res[8]=5'b00000; t_fl[8]=3'b001;
    for (int k = 0; k < 9; k++) begin
      drive(t_op[k], t_a[k], t_b[k], t_cin[k]);
      tick();
      checks++;
      if (obs !== exp_data(t_res[k], t_fl[k][2], t_fl[k][1], t_fl[k][0])) begin
        failures++;
        $display("FAIL op_vec%0d got=%h want=%h", k, obs,
                 exp_data(t_res[k], t_fl[k][2], t_fl[k][1], t_fl[k][0]));
      end
      return_null();
      checks++;
      if (obs !== {1'b1, 1'b0, 16'h0}) begin
        failures++;
        $display("FAIL op_return%0d got=%h want=%h", k, obs, {1'b1, 1'b0, 16'h0});
      end
    end
  endtask

  task automatic test_handshake();
    bus.ki = 1'b0;
    drive(3'b000, 5'd7, 5'd5, 1'b0);
    tick();
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL hs_no_ki got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    bus.ki = 1'b1;
    tick();
    checks++;
    if (obs !== exp_data(5'b01100, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL hs_data got=%h want=%h", obs, exp_data(5'b01100, 1'b0, 1'b0, 1'b0));
    end
    bus.ki = 1'b0;
    tick();
    drive(3'b101, 5'd1, 5'd2, 1'b1);
    tick();
    checks++;
    if (obs !== exp_data(5'b01100, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL hs_hold got=%h want=%h", obs, exp_data(5'b01100, 1'b0, 1'b0, 1'b0));
    end
    drive_null();
    tick();
    checks++;
    if (obs !== {1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL hs_null got=%h want=%h", obs, {1'b0, 1'b0, 16'h0});
    end
    bus.ki = 1'b1;
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL hs_ko got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
  endtask

  task automatic test_partial();
    bus.ki   = 1'b1;
    bus.a_dr = enc(5'd9);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL partial_a got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    bus.b_dr  = enc(5'd3);
    bus.op_dr = enc3(3'b000);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL partial_nocin got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    bus.cin_dr = encf(1'b1);
    tick();
    checks++;
    if (obs !== exp_data(5'b01101, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL partial_done got=%h want=%h", obs, exp_data(5'b01101, 1'b0, 1'b0, 1'b0));
    end
    return_null();
  endtask

  task automatic test_illegal();
    drive(3'b000, 5'd7, 5'd5, 1'b0);
    tick();
    bus.a_dr[7:6] = 2'b11;
    tick();
    checks++;
    if (obs !== {1'b0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL illegal_err got=%h want=%h", obs, {1'b0, 1'b1, 16'h0});
    end
    return_null();
    drive(3'b000, 5'd7, 5'd5, 1'b0);
    tick();
    checks++;
    if (obs !== {1'b0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL illegal_sticky got=%h want=%h", obs, {1'b0, 1'b1, 16'h0});
    end
    drive_null();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL illegal_clear got=%h want=%h", obs, {1'b1, 1'b0, 16'h0});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.ki = 1'b1;
    drive_null();
    test_reset();
    test_ops();
    test_handshake();
    test_partial();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
